// File: rtl/ch_spi_readout_multi.sv
// Snapshots trigger_cnt and NUM_CH channel counters into a byte-aligned shadow frame and shifts one byte
// (or a tail burst) MSB first onto CNT_SER; the first bit follows the START edge and DONE pulses one cycle after the last bit.
module ch_spi_readout_multi #(
  parameter int NUM_CH = 5,
  parameter int CNT_W = 10,
  parameter int TRIG_W = 3,
  parameter int BYTE_W = 8,
  localparam int RAW_W = TRIG_W + NUM_CH * CNT_W,
  localparam int FRAME_W = ((RAW_W + BYTE_W - 1) / BYTE_W) * BYTE_W,
  localparam int NUM_BYTES = FRAME_W / BYTE_W,
  localparam int SEL_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                    SPI_CLK,
  input  logic                    RST,
  input  logic                    INST_READOUT,
  input  logic                    START,
  input  logic [SEL_W-1:0]        SELECT_REG,
  input  logic                    BURST,
  input  logic [TRIG_W-1:0]       trigger_cnt,
  input  logic [NUM_CH*CNT_W-1:0] CNT,
  output logic                    CNT_SER,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    OVERRUN
);

  localparam int CNT_BW = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state;
  logic               sync1;
  logic               sync2;
  logic               sync_dly;
  logic               cap;
  logic [FRAME_W-1:0] live;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-1:0] src;
  logic [FRAME_W-1:0] sel_frame;
  logic [FRAME_W-1:0] shreg;
  logic [SEL_W-1:0]   sel_c;
  logic [CNT_BW-1:0]  len;
  logic [CNT_BW-1:0]  len_q;
  logic [CNT_BW-1:0]  bit_cnt;

  assign cap  = sync2 & ~sync_dly;
  assign live = FRAME_W'({trigger_cnt, CNT});

  // A same-edge snapshot wins over the stored frame, so the fresh data is what gets sent.
  always_comb begin
    sel_c = SELECT_REG;
    if (32'(SELECT_REG) > NUM_BYTES - 1) sel_c = SEL_W'(NUM_BYTES - 1);
    src       = cap ? live : shadow;
    sel_frame = src << (sel_c * BYTE_W);
    len       = BURST ? CNT_BW'((NUM_BYTES - 32'(sel_c)) * BYTE_W) : CNT_BW'(BYTE_W);
  end

  // ST_DONE covers the cycle the last bit is on the line; its exit edge raises DONE and returns to idle,
  // so a START seen at that edge is ignored and the next one is taken one edge later.
  always_ff @(posedge SPI_CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync_dly <= 1'b0;
      shadow   <= '0;
      shreg    <= '0;
      len_q    <= '0;
      bit_cnt  <= '0;
      CNT_SER  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      sync1    <= INST_READOUT;
      sync2    <= sync1;
      sync_dly <= sync2;

      if (cap) begin
        if (BUSY) OVERRUN <= 1'b1;
        else      shadow  <= live;
      end

      case (state)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            CNT_SER <= sel_frame[FRAME_W-1];
            shreg   <= sel_frame << 1;
            len_q   <= len;
            bit_cnt <= CNT_BW'(1);
            BUSY    <= 1'b1;
            OVERRUN <= 1'b0;
            state   <= (len == CNT_BW'(1)) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          CNT_SER <= shreg[FRAME_W-1];
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CNT_BW'(1);
          if (bit_cnt + CNT_BW'(1) == len_q) state <= ST_DONE;
        end
        ST_DONE: begin
          CNT_SER <= 1'b0;
          BUSY    <= 1'b0;
          DONE    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ch_spi_readout_multi.sv
// Directed bench for ch_spi_readout_multi at default parameters.
// Expected serial bits are queued per transmission from a reference frame and popped per cycle.
module tb_ch_spi_readout_multi;

  localparam int NUM_CH    = 5;
  localparam int CNT_W     = 10;
  localparam int TRIG_W    = 3;
  localparam int BYTE_W    = 8;
  localparam int FRAME_W   = 56;
  localparam int NUM_BYTES = 7;
  localparam int SEL_W     = 3;

  logic                    SPI_CLK = 1'b0;
  logic                    RST;
  logic                    INST_READOUT;
  logic                    START;
  logic [SEL_W-1:0]        SELECT_REG;
  logic                    BURST;
  logic [TRIG_W-1:0]       trigger_cnt;
  logic [NUM_CH*CNT_W-1:0] CNT;
  logic                    CNT_SER;
  logic                    BUSY;
  logic                    DONE;
  logic                    OVERRUN;

  int                 checks = 0;
  int                 errors = 0;
  logic               exp_q[$];
  logic [FRAME_W-1:0] model_frame;
  logic [FRAME_W-1:0] got;
  logic [63:0]        rnd;

  always #5 SPI_CLK = ~SPI_CLK;

  ch_spi_readout_multi dut (
    .SPI_CLK     (SPI_CLK),
    .RST         (RST),
    .INST_READOUT(INST_READOUT),
    .START       (START),
    .SELECT_REG  (SELECT_REG),
    .BURST       (BURST),
    .trigger_cnt (trigger_cnt),
    .CNT         (CNT),
    .CNT_SER     (CNT_SER),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .OVERRUN     (OVERRUN)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int push_exp(input logic [SEL_W-1:0] sel, input logic burst);
    int s;
    int n;
    s = (int'(sel) > NUM_BYTES - 1) ? NUM_BYTES - 1 : int'(sel);
    n = burst ? (NUM_BYTES - s) * BYTE_W : BYTE_W;
    for (int i = 0; i < n; i++) exp_q.push_back(model_frame[FRAME_W-1 - s*BYTE_W - i]);
    return n;
  endfunction

  // chained: START was already raised by the previous call's chain_next step.
  task automatic run_tx(input logic [SEL_W-1:0] sel, input logic burst, input bit chained,
                        input bit chain_next, input logic [SEL_W-1:0] nsel, input logic nburst);
    int   n;
    logic eb;
    if (!chained) begin
      @(posedge SPI_CLK); #1;
      START = 1'b1; SELECT_REG = sel; BURST = burst;
    end
    n   = push_exp(sel, burst);
    got = '0;
    @(posedge SPI_CLK); #1;
    START = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge SPI_CLK);
      eb  = exp_q.pop_front();
      got = {got[FRAME_W-2:0], CNT_SER};
      chk("ser_bit", CNT_SER, eb);
      chk("busy_hi", BUSY, 1'b1);
      chk("done_lo", DONE, 1'b0);
      if (j == n - 1 && chain_next) begin
        START = 1'b1; SELECT_REG = nsel; BURST = nburst;
      end
      @(posedge SPI_CLK);
    end
    @(negedge SPI_CLK);
    chk("busy_end", BUSY, 1'b0);
    chk("done_pulse", DONE, 1'b1);
    chk("ser_idle", CNT_SER, 1'b0);
  endtask

  task automatic snapshot(input logic [TRIG_W-1:0] trig, input logic [NUM_CH*CNT_W-1:0] cnt);
    @(posedge SPI_CLK); #1;
    trigger_cnt = trig; CNT = cnt; INST_READOUT = 1'b1;
    repeat (3) @(posedge SPI_CLK);
    #1 INST_READOUT = 1'b0;
    repeat (3) @(posedge SPI_CLK);
    model_frame = {3'b000, trig, cnt};
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; INST_READOUT = 1'b0; BURST = 1'b0; SELECT_REG = '0;
    trigger_cnt = '0; CNT = '0; model_frame = '0;

    // Reset with inputs toggling
    repeat (2) begin
      @(posedge SPI_CLK); #1;
      START = ~START; INST_READOUT = ~INST_READOUT; trigger_cnt = 3'b111; CNT = '1; BURST = ~BURST;
      @(negedge SPI_CLK);
      chk("rst_ser", CNT_SER, 1'b0);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_ovr", OVERRUN, 1'b0);
    end
    RST = 1'b0; START = 1'b0; INST_READOUT = 1'b0; BURST = 1'b0;
    run_tx(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("rst_zero_byte", got[7:0], 8'h00);

    // Single byte from the reference frame
    snapshot(3'b101, {10'h2AA, 40'h0});
    run_tx(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("byte0", got[7:0], 8'h16);
    run_tx(3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("byte1", got[7:0], 8'hAA);
    run_tx(3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    // Random frame: bursts, clamp, full frame, back-to-back START
    rnd = {$urandom, $urandom};
    rnd[0] = 1'b1;
    snapshot(3'b011, rnd[49:0]);
    run_tx(3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("burst5", got[15:0], rnd[15:0]);
    run_tx(3'd7, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("clamp_byte6", got[7:0], rnd[7:0]);
    run_tx(3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("full_frame", got, {3'b000, 3'b011, rnd[49:0]});
    run_tx(3'd2, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
    run_tx(3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);

    // Strobe while shifting: dropped, flagged, old snapshot kept
    @(posedge SPI_CLK); #1;
    trigger_cnt = 3'b110; CNT = ~rnd[49:0]; INST_READOUT = 1'b1;
    run_tx(3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("ovr_set", OVERRUN, 1'b1);
    INST_READOUT = 1'b0;
    repeat (3) @(posedge SPI_CLK);
    @(negedge SPI_CLK);
    chk("ovr_held", OVERRUN, 1'b1);
    run_tx(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("ovr_clr", OVERRUN, 1'b0);
    run_tx(3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("ovr_old_byte6", got[7:0], rnd[7:0]);

    // Snapshot on the same edge as START: new byte 0 goes out
    @(posedge SPI_CLK); #1;
    trigger_cnt = 3'b010; CNT = {10'h155, 10'h000, 10'h3C3, 10'h000, 10'h001}; INST_READOUT = 1'b1;
    @(posedge SPI_CLK); #1;
    model_frame = {3'b000, 3'b010, 10'h155, 10'h000, 10'h3C3, 10'h000, 10'h001};
    run_tx(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("sim_byte0", got[7:0], 8'h09);
    chk("sim_no_ovr", OVERRUN, 1'b0);
    INST_READOUT = 1'b0;
    repeat (3) @(posedge SPI_CLK);

    // Reset during bit 3 of a burst
    @(posedge SPI_CLK); #1;
    START = 1'b1; SELECT_REG = 3'd1; BURST = 1'b1;
    @(posedge SPI_CLK); #1;
    START = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge SPI_CLK);
      chk("mr_bit", CNT_SER, model_frame[FRAME_W-1-BYTE_W-j]);
      if (j < 2) @(posedge SPI_CLK);
    end
    RST = 1'b1;
    @(posedge SPI_CLK);
    @(negedge SPI_CLK);
    chk("mr_busy", BUSY, 1'b0);
    chk("mr_ser", CNT_SER, 1'b0);
    chk("mr_done", DONE, 1'b0);
    RST = 1'b0;
    repeat (3) begin
      @(negedge SPI_CLK);
      chk("mr_no_done", DONE, 1'b0);
      chk("mr_idle", BUSY, 1'b0);
    end
    model_frame = '0;
    run_tx(3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("mr_zero_frame", got, 56'h0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
